// File: rtl/ram2e_pkg.sv
`default_nettype none
// ============================================================================
// Package     : ram2e_pkg
// Description : Shared constants for the RAM2E SDRAM sequencer: command
//               encodings, init-state enum, Apple-cycle slot numbers.
// Revision    : 1.0 - initial release
// ============================================================================
package ram2e_pkg;

  // SDRAM commands as {nCS, nRAS, nCAS, nRWE}
  localparam logic [3:0] CMD_NOP = 4'b1111;
  localparam logic [3:0] CMD_ACT = 4'b0011;
  localparam logic [3:0] CMD_RD  = 4'b0101;
  localparam logic [3:0] CMD_WR  = 4'b0100;
  localparam logic [3:0] CMD_REF = 4'b0001;
  localparam logic [3:0] CMD_PRE = 4'b0010;
  localparam logic [3:0] CMD_MRS = 4'b0000;

  // Power-up sequence states; RUN is terminal until reset
  typedef enum logic [2:0] {
    WAIT  = 3'd0,
    CKEON = 3'd1,
    PRE   = 3'd2,
    REF1  = 3'd3,
    MRS   = 3'd4,
    REF2  = 3'd5,
    RUN   = 3'd6
  } init_state_e;

  // Slot numbers (value of S while the command is decided)
  localparam logic [3:0] S_VACT  = 4'h2;
  localparam logic [3:0] S_VRD   = 4'h3;
  localparam logic [3:0] S_REF   = 4'h6;
  localparam logic [3:0] S_CACT  = 4'h8;
  localparam logic [3:0] S_CRW   = 4'h9;
  localparam logic [3:0] S_CKOFF = 4'hB;

  // Number of C14M cycles spent in each init state
  function automatic logic [15:0] init_len(input init_state_e st,
                                           input logic [15:0] wait_len,
                                           input logic [15:0] ref_len);
    logic [15:0] len;
    case (st)
      WAIT:       len = wait_len;
      CKEON:      len = 16'd16;
      PRE:        len = 16'd3;
      REF1, REF2: len = ref_len;
      MRS:        len = 16'd4;
      default:    len = 16'd0;
    endcase
    return len;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ram2e_phase_counter.sv
`default_nettype none
// ============================================================================
// Module      : ram2e_phase_counter
// Description : Registers the asynchronous PHI1 input, detects its rising
//               edge and runs the saturating Apple phase counter S.
// Revision    : 1.0 - initial release
// ============================================================================
module ram2e_phase_counter (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       phi1_i,
  input  logic       ready_i,
  output logic [3:0] s_o,
  output logic       s1_entry_o
);

  logic       phi_q;
  logic       phi_prev_q;
  logic [3:0] s_q;
  logic [3:0] s_d;
  logic       w_phi_rise;

  assign w_phi_rise = phi_q & ~phi_prev_q;
  assign s1_entry_o = w_phi_rise & ready_i;
  assign s_o        = s_q;

  // PHI1 capture, edge history and phase register
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      phi_q      <= 1'b0;
      phi_prev_q <= 1'b0;
      s_q        <= 4'h0;
    end else begin
      phi_q      <= phi1_i;
      phi_prev_q <= phi_q;
      s_q        <= s_d;
    end
  end

  // Resync to 1 on a PHI1 edge; 0 and F are parking values, others advance
  always_comb begin
    s_d = s_q;
    if (s1_entry_o) begin
      s_d = 4'h1;
    end else if ((s_q != 4'h0) && (s_q != 4'hF)) begin
      s_d = s_q + 4'h1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/ram2e_sdram_sched.sv
`default_nettype none
// ============================================================================
// Module      : ram2e_sdram_sched
// Description : RAM2E SDRAM command sequencer. Runs power-up init, then per
//               Apple cycle issues video read, CPU read/write and refreshes
//               paid from a saturating refresh-debt counter.
// Revision    : 1.0 - initial release
// ============================================================================
module ram2e_sdram_sched
  import ram2e_pkg::*;
#(
  parameter int unsigned INIT_WAIT    = 65280,
  parameter int unsigned INIT_REF     = 8,
  parameter int unsigned REF_PERIOD   = 8,
  parameter int unsigned REF_DEBT_MAX = 7
) (
  input  logic       C14M,
  input  logic       nRESET,
  input  logic       PHI1,
  input  logic       nWE80,
  output logic       CKE,
  output logic       nCS,
  output logic       nRAS,
  output logic       nCAS,
  output logic       nRWE,
  output logic       AP,
  output logic       ModeLoad,
  output logic       VidSlot,
  output logic       CpuSlot,
  output logic       RowSel,
  output logic       Ready,
  output logic [3:0] S
);

  localparam int unsigned c_PER_W = (REF_PERIOD > 1) ? $clog2(REF_PERIOD) : 1;

  init_state_e        state_q, state_d;
  logic [15:0]        cnt_q, cnt_d;
  logic [15:0]        w_len;

  logic [3:0]         cmd_q, cmd_d;
  logic               cke_q, cke_d;
  logic               ap_q, ap_d;
  logic               mode_q, mode_d;
  logic               vid_q, vid_d;
  logic               cpu_q, cpu_d;
  logic               row_q, row_d;
  logic               ready_q, ready_d;

  logic [2:0]         debt_q, debt_d;
  logic [c_PER_W-1:0] apple_q, apple_d;
  logic               w_ref_go;
  logic               w_accrue;
  logic               w_s1_entry;
  logic [3:0]         w_s;

  ram2e_phase_counter u_phase (
    .clk_i      (C14M),
    .rst_n_i    (nRESET),
    .phi1_i     (PHI1),
    .ready_i    (ready_q),
    .s_o        (w_s),
    .s1_entry_o (w_s1_entry)
  );

  assign w_len = init_len(state_q, 16'(INIT_WAIT), 16'(INIT_REF * 8));

  // Init state register with its per-state cycle counter
  always_ff @(posedge C14M) begin
    if (!nRESET) begin
      state_q <= WAIT;
      cnt_q   <= 16'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Advance to the next init state when the current one has run its length
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 16'd1;
    if (state_q == RUN) begin
      cnt_d = cnt_q;
    end else if (cnt_q == (w_len - 16'd1)) begin
      cnt_d = 16'd0;
      case (state_q)
        WAIT:    state_d = CKEON;
        CKEON:   state_d = PRE;
        PRE:     state_d = REF1;
        REF1:    state_d = MRS;
        MRS:     state_d = REF2;
        REF2:    state_d = RUN;
        default: state_d = RUN;
      endcase
    end
  end

  // Command and strobe decode from init state, or from S once running
  always_comb begin
    cmd_d    = CMD_NOP;
    cke_d    = 1'b1;
    ap_d     = 1'b0;
    mode_d   = 1'b0;
    vid_d    = 1'b0;
    cpu_d    = 1'b0;
    row_d    = 1'b0;
    ready_d  = 1'b0;
    w_ref_go = 1'b0;
    case (state_q)
      WAIT: cke_d = 1'b0;
      CKEON: cke_d = 1'b1;
      PRE: begin
        if (cnt_q == 16'd0) begin
          cmd_d = CMD_PRE;
          ap_d  = 1'b1;
        end
      end
      // one REF at the start of every 8-cycle group
      REF1, REF2: begin
        if (cnt_q[2:0] == 3'd0) cmd_d = CMD_REF;
      end
      MRS: begin
        if (cnt_q == 16'd0) begin
          cmd_d  = CMD_MRS;
          mode_d = 1'b1;
        end
      end
      RUN: begin
        ready_d = 1'b1;
        // clock is gated for the tail of the Apple cycle, and while parked at F
        cke_d   = (w_s < S_CKOFF);
        case (w_s)
          S_VACT, S_CACT: begin
            cmd_d = CMD_ACT;
            row_d = 1'b1;
          end
          S_VRD: begin
            cmd_d = CMD_RD;
            ap_d  = 1'b1;
            vid_d = 1'b1;
          end
          S_REF: begin
            if (debt_q != 3'd0) begin
              cmd_d    = CMD_REF;
              w_ref_go = 1'b1;
            end
          end
          S_CRW: begin
            cmd_d = nWE80 ? CMD_RD : CMD_WR;
            ap_d  = 1'b1;
            cpu_d = 1'b1;
          end
          default: cmd_d = CMD_NOP;
        endcase
      end
      default: cke_d = 1'b0;
    endcase
  end

  // Registered SDRAM-facing outputs
  always_ff @(posedge C14M) begin
    if (!nRESET) begin
      cmd_q   <= CMD_NOP;
      cke_q   <= 1'b0;
      ap_q    <= 1'b0;
      mode_q  <= 1'b0;
      vid_q   <= 1'b0;
      cpu_q   <= 1'b0;
      row_q   <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      cmd_q   <= cmd_d;
      cke_q   <= cke_d;
      ap_q    <= ap_d;
      mode_q  <= mode_d;
      vid_q   <= vid_d;
      cpu_q   <= cpu_d;
      row_q   <= row_d;
      ready_q <= ready_d;
    end
  end

  // Accrue one refresh every REF_PERIOD Apple cycles; pay one per S6 REF
  always_comb begin
    apple_d  = apple_q;
    w_accrue = 1'b0;
    if (w_s1_entry) begin
      if (apple_q == c_PER_W'(REF_PERIOD - 1)) begin
        apple_d  = '0;
        w_accrue = 1'b1;
      end else begin
        apple_d = apple_q + 1'b1;
      end
    end
    debt_d = debt_q;
    if (w_accrue && !w_ref_go) begin
      if (debt_q != 3'(REF_DEBT_MAX)) debt_d = debt_q + 3'd1;
    end else if (w_ref_go && !w_accrue) begin
      debt_d = debt_q - 3'd1;
    end
  end

  // Refresh debt and Apple-cycle counter registers
  always_ff @(posedge C14M) begin
    if (!nRESET) begin
      debt_q  <= 3'd0;
      apple_q <= '0;
    end else begin
      debt_q  <= debt_d;
      apple_q <= apple_d;
    end
  end

  assign {nCS, nRAS, nCAS, nRWE} = cmd_q;
  assign CKE      = cke_q;
  assign AP       = ap_q;
  assign ModeLoad = mode_q;
  assign VidSlot  = vid_q;
  assign CpuSlot  = cpu_q;
  assign RowSel   = row_q;
  assign Ready    = ready_q;
  assign S        = w_s;

endmodule
`default_nettype wire

// File: tb/tb_ram2e_sdram_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_ram2e_sdram_sched
// Description : Scoreboard bench for ram2e_sdram_sched with a cycle-level
//               reference model and randomized PHI1 / nWE80 stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ram2e_sdram_sched;

  localparam int W        = 1000;   // shortened power-up wait
  localparam int REF_PER  = 8;
  localparam int DEBT_MAX = 7;
  localparam int RUN_AT   = W + 151; // edges (0-based) before RUN is reached

  localparam logic [3:0] NOP = 4'b1111, ACT = 4'b0011, RD = 4'b0101,
                         WR  = 4'b0100, REF = 4'b0001, PRE = 4'b0010,
                         MRS = 4'b0000;

  typedef struct packed {
    logic       cke;
    logic [3:0] cmd;
    logic       ap;
    logic       ml;
    logic       vid;
    logic       cpu;
    logic       row;
    logic       rdy;
    logic [3:0] s;
  } obs_t;

  logic       clk = 1'b0;
  logic       nRESET, PHI1, nWE80;
  logic       CKE, nCS, nRAS, nCAS, nRWE, AP, ModeLoad, VidSlot, CpuSlot, RowSel, Ready;
  logic [3:0] S;

  obs_t  exp_q[$];
  string tag_q[$];
  string cur = "start";
  int    n_cmp = 0;
  int    n_bad = 0;

  // reference model state (values as seen after the most recent edge)
  int m_t = 0, m_s = 0, m_debt = 0, m_entries = 0;
  bit m_ready = 0, m_h1 = 0, m_h2 = 0;

  always #5 clk = ~clk;

  ram2e_sdram_sched #(
    .INIT_WAIT   (W),
    .INIT_REF    (8),
    .REF_PERIOD  (REF_PER),
    .REF_DEBT_MAX(DEBT_MAX)
  ) dut (
    .C14M    (clk),
    .nRESET  (nRESET),
    .PHI1    (PHI1),
    .nWE80   (nWE80),
    .CKE     (CKE),
    .nCS     (nCS),
    .nRAS    (nRAS),
    .nCAS    (nCAS),
    .nRWE    (nRWE),
    .AP      (AP),
    .ModeLoad(ModeLoad),
    .VidSlot (VidSlot),
    .CpuSlot (CpuSlot),
    .RowSel  (RowSel),
    .Ready   (Ready),
    .S       (S)
  );

  // Drive one cycle of inputs and push what the outputs must be after the edge
  task automatic step(input bit phi, input bit nwe, input bit rstn);
    obs_t e;
    int   u;
    int   s_next;
    bit   rise, acc, refd;
    PHI1   = phi;
    nWE80  = nwe;
    nRESET = rstn;
    e = '{cke: 1'b0, cmd: NOP, ap: 1'b0, ml: 1'b0, vid: 1'b0, cpu: 1'b0,
          row: 1'b0, rdy: 1'b0, s: 4'h0};
    if (!rstn) begin
      m_t = 0; m_s = 0; m_debt = 0; m_entries = 0;
      m_ready = 0; m_h1 = 0; m_h2 = 0;
    end else begin
      u = m_t;
      m_t++;
      rise = m_h1 && !m_h2;
      refd = 0;
      e.cke = 1'b1;
      if (u < W) e.cke = 1'b0;
      else if (u < W + 16) e.cke = 1'b1;
      else if (u < W + 19) begin
        if (u == W + 16) begin e.cmd = PRE; e.ap = 1'b1; end
      end else if (u < W + 83) begin
        if ((u - (W + 19)) % 8 == 0) e.cmd = REF;
      end else if (u < W + 87) begin
        if (u == W + 83) begin e.cmd = MRS; e.ml = 1'b1; end
      end else if (u < RUN_AT) begin
        if ((u - (W + 87)) % 8 == 0) e.cmd = REF;
      end else begin
        e.rdy = 1'b1;
        e.cke = (m_s < 11);
        case (m_s)
          2, 8: begin e.cmd = ACT; e.row = 1'b1; end
          3:    begin e.cmd = RD; e.ap = 1'b1; e.vid = 1'b1; end
          6:    if (m_debt > 0) begin e.cmd = REF; refd = 1; end
          9:    begin e.cmd = nwe ? RD : WR; e.ap = 1'b1; e.cpu = 1'b1; end
          default: ;
        endcase
      end
      acc = 0;
      if (rise && m_ready) begin
        s_next = 1;
        m_entries++;
        acc = (m_entries % REF_PER) == 0;
      end else if (m_s == 0 || m_s == 15) s_next = m_s;
      else s_next = m_s + 1;
      if (acc && !refd) m_debt = (m_debt < DEBT_MAX) ? m_debt + 1 : DEBT_MAX;
      else if (refd && !acc) m_debt = m_debt - 1;
      m_s = s_next;
      e.s = 4'(s_next);
      m_ready = e.rdy;
      m_h2 = m_h1;
      m_h1 = phi;
    end
    exp_q.push_back(e);
    tag_q.push_back(cur);
    @(negedge clk);
  endtask

  // n Apple cycles with PHI1 high for the first half of each period
  task automatic apple(input int period, input int n);
    for (int c = 0; c < n; c++)
      for (int i = 0; i < period; i++)
        step(i < (period + 1) / 2, 1'($urandom % 2), 1'b1);
  endtask

  // Monitor: compare every DUT sample against the oldest expectation
  initial begin
    obs_t  act, e;
    string t;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        act = {CKE, nCS, nRAS, nCAS, nRWE, AP, ModeLoad, VidSlot, CpuSlot, RowSel, Ready, S};
        n_cmp++;
        if (act !== e) begin
          n_bad++;
          $display("FAIL %s @%0t: got cke/cmd/ap/ml/vid/cpu/row/rdy/s=%b/%b/%b/%b/%b/%b/%b/%b/%h want %b/%b/%b/%b/%b/%b/%b/%b/%h",
                   t, $time, act.cke, act.cmd, act.ap, act.ml, act.vid, act.cpu, act.row, act.rdy, act.s,
                   e.cke, e.cmd, e.ap, e.ml, e.vid, e.cpu, e.row, e.rdy, e.s);
        end
      end
    end
  end

  // Stimulus
  initial begin
    bit found;
    nRESET = 1'b0; PHI1 = 1'b0; nWE80 = 1'b1;
    @(negedge clk);
    cur = "reset";
    repeat (3) step(1'($urandom % 2), 1'b1, 1'b0);
    // PHI1 toggles throughout init and must be ignored
    cur = "init";
    for (int i = 0; i < RUN_AT + 3; i++) step(1'((i / 7) % 2), 1'($urandom % 2), 1'b1);
    cur = "run14";
    apple(14, 30);
    cur = "debt_build";
    apple(4, 24);
    cur = "debt_repay";
    apple(14, 6);
    cur = "park";
    repeat (100) step(1'b0, 1'($urandom % 2), 1'b1);
    cur = "resume";
    apple(14, 4);
    cur = "random";
    for (int k = 0; k < 40; k++) apple($urandom_range(3, 20), 1);
    // reset pulse while S shows 9
    cur = "rst_s9";
    found = 0;
    for (int i = 0; i < 60 && !found; i++) begin
      if (m_s == 9) begin
        step(1'((i % 14) < 7), 1'($urandom % 2), 1'b0);
        found = 1;
      end else begin
        step(1'((i % 14) < 7), 1'($urandom % 2), 1'b1);
      end
    end
    if (!found) begin
      n_cmp++; n_bad++;
      $display("FAIL rst_s9: S=9 not reached within 60 cycles, got %0d want 9", m_s);
    end
    cur = "replay";
    for (int i = 0; i < RUN_AT + 3; i++) step(1'((i / 5) % 2), 1'($urandom % 2), 1'b1);
    cur = "run_after";
    apple(14, 10);
    @(posedge clk);
    #2;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending expectations want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
